// File: rtl/diferenciador_pkg.sv
// Shared defaults, occupancy-state encoding and FIFO entry layout for the
// running-sum differentiator.
package diferenciador_pkg;

    localparam int W_SUM_D = 8;
    localparam int W_INC_D = 10;
    localparam int DEPTH_D = 4;

    typedef enum logic [1:0] {
        VACIO   = 2'd0,
        PARCIAL = 2'd1,
        LLENO   = 2'd2
    } estado_t;

    // FIFO entry: wrap flag sits above the recovered increment.
    typedef struct packed {
        logic               wrap;
        logic [W_INC_D-1:0] inc;
    } entrada_t;

    localparam int W_ENTRADA_D = $bits(entrada_t);

endpackage

// File: rtl/diferenciador_acum_fifo_sinc.sv
// Synchronous FIFO with extra-MSB pointers; the head reads as zero when empty
// so downstream never sees stale data.
module fifo_sinc #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Guard against overrun/underrun even if the caller misbehaves.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = o_empty ? {W{1'b0}} : r_mem[r_rd_ptr[AW-1:0]];

    // Storage array and write pointer.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_wr_ptr <= {(AW+1){1'b0}};
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Read pointer.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= {(AW+1){1'b0}};
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end else begin
            r_rd_ptr <= r_rd_ptr;
        end
    end

endmodule

// File: rtl/diferenciador_acum.sv
// Recovers per-sample increments from an accumulator's running-sum stream,
// flags modulo wraps and queues {wrap, inc} behind valid/ready handshakes.
module diferenciador_acum
    import diferenciador_pkg::*;
#(
    parameter int W_SUM = W_SUM_D,
    parameter int W_INC = W_INC_D,
    parameter int DEPTH = DEPTH_D
) (
    input  logic                   clk,
    input  logic                   i_rs,
    input  logic [W_SUM-1:0]       i_sum,
    input  logic                   i_sum_clr,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [W_INC-1:0]       o_inc,
    output logic                   o_wrap,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               r_rst_meta;
    logic               r_rst_sync;
    logic [W_SUM-1:0]   r_prev;
    estado_t            r_estado;
    estado_t            w_estado_sig;
    logic               w_push;
    logic               w_pop;
    logic [W_SUM-1:0]   w_ref;
    logic [W_SUM-1:0]   w_delta;
    logic               w_wrap;
    logic [W_INC:0]     w_entrada;
    logic [W_INC:0]     w_cabeza;
    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;

    // Reset synchronizer: asserts immediately, releases on the clock.
    always_ff @(posedge clk or negedge i_rs) begin
        if (!i_rs) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    // Handshake flags decode only registered state, never the peer's strobe.
    assign o_valid = (r_estado != VACIO) & ~w_empty;
    assign o_ready = (r_estado != LLENO) & ~w_full;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    assign w_ref     = i_sum_clr ? {W_SUM{1'b0}} : r_prev;
    assign w_delta   = i_sum - w_ref;
    assign w_wrap    = ~i_sum_clr & (i_sum < r_prev);
    assign w_entrada = {w_wrap, W_INC'(w_delta)};

    // Last accepted running sum.
    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_prev <= {W_SUM{1'b0}};
        end else if (w_push) begin
            r_prev <= i_sum;
        end else begin
            r_prev <= r_prev;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_estado <= VACIO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next occupancy state from push/pop and current count.
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            VACIO: begin
                if (w_push) begin
                    w_estado_sig = PARCIAL;
                end else begin
                    w_estado_sig = VACIO;
                end
            end
            PARCIAL: begin
                if (w_push && !w_pop && (w_count == CW'(DEPTH - 1))) begin
                    w_estado_sig = LLENO;
                end else if (w_pop && !w_push && (w_count == CW'(1))) begin
                    w_estado_sig = VACIO;
                end else begin
                    w_estado_sig = PARCIAL;
                end
            end
            LLENO: begin
                if (w_pop) begin
                    w_estado_sig = PARCIAL;
                end else begin
                    w_estado_sig = LLENO;
                end
            end
            default: begin
                w_estado_sig = VACIO;
            end
        endcase
    end

    fifo_sinc #(
        .DEPTH (DEPTH),
        .W     (W_INC + 1)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (r_rst_sync),
        .i_push  (w_push),
        .i_data  (w_entrada),
        .i_pop   (w_pop),
        .o_data  (w_cabeza),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_inc   = w_cabeza[W_INC-1:0];
    assign o_wrap  = w_cabeza[W_INC];
    assign o_count = w_count;

endmodule

// File: doc/diferenciador_acum.md
Name: diferenciador_acum

Overview:
- Inverse of the running-sum accumulator. Takes the 8-bit running-sum stream that the accumulator produces and recovers the 10-bit per-sample increments that built it.
- Flags any modulo-256 wrap of the sum.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.
- Sits downstream of the accumulator output for checking and for re-playing its input stream.

Parameters:
- W_SUM, 8, running-sum input width.
- W_INC, 10, recovered-increment output width; must be ≥ W_SUM.
- DEPTH, 4, output FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  single clock, rising edge.
- i_rs  input  1  asynchronous reset, active-low: 0 resets the block.
- i_sum  input  W_SUM  running-sum sample.
- i_sum_clr  input  1  qualifies i_sum: the accumulator was cleared before this sample.
- i_valid  input  1  i_sum / i_sum_clr are valid.
- o_ready  output  1  block can accept a sample this cycle.
- o_inc  output  W_INC  recovered increment at the FIFO head.
- o_wrap  output  1  the head entry crossed a modulo-2^W_SUM wrap.
- o_valid  output  1  o_inc / o_wrap are valid.
- i_ready  input  1  consumer accepts the head this cycle.
- o_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (i_rs=0, async assert, sync release):
  - prev register = 0; FIFO empty; state = VACIO.
  - o_valid=0, o_inc=0, o_wrap=0, o_count=0, o_ready=1.
- Accept: push = i_valid & o_ready. Pop: pop = o_valid & i_ready. No combinational path from i_valid to o_ready, or from i_ready to o_valid.
- Increment on push:
  - ref = i_sum_clr ? 0 : prev.
  - delta = (i_sum − ref) mod 2^W_SUM, zero-extended to W_INC.
  - wrap = ~i_sum_clr & (i_sum < prev).
  - {wrap, delta} is written to the FIFO tail; prev <= i_sum.
- Latency: a sample accepted at edge N appears on o_valid/o_inc after edge N (first cycle following acceptance). Outputs come from registered FIFO head state.
- Empty output: when the FIFO is empty, o_inc=0 and o_wrap=0 (outputs forced to 0, not stale data).
- State machine, derived from occupancy:
  - VACIO: count=0; o_valid=0, o_ready=1.
  - PARCIAL: 0<count<DEPTH; o_valid=1, o_ready=1.
  - LLENO: count=DEPTH; o_valid=1, o_ready=0.
- Transitions:
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged (possible only in PARCIAL).
  - VACIO→PARCIAL on push. PARCIAL→LLENO on push without pop at count=DEPTH−1.
  - LLENO→PARCIAL on pop. PARCIAL→VACIO on pop without push at count=1.
- Pointers: read/write pointers wrap modulo DEPTH. Full/empty use an extra MSB, never pointer equality alone.
- i_valid while o_ready=0: the sample is not taken, prev is unchanged, and the source must hold it.
- Reset mid-operation: all FIFO contents are discarded, prev=0, and the next sample's delta is i_sum.
- i_sum equal to prev: delta=0, wrap=0; still pushed as a valid entry.

Decomposition:
- Package diferenciador_pkg: W_SUM/W_INC/DEPTH defaults, the state encoding (VACIO=2'd0, PARCIAL=2'd1, LLENO=2'd2), and the FIFO entry layout {wrap, inc}.
- Sub-module fifo_sinc: synchronous FIFO, DEPTH × (W_INC+1), with count/full/empty outputs.
- Top level: prev register, delta/wrap logic and handshake glue.

Test Plan:
- Sequence: reset, then push sums 4, 10, 20 with i_ready=1 → o_inc = 4, 6, 10, each with o_wrap=0, each one cycle after acceptance.
- Wrap: push 250, then 4 → second entry o_inc=10, o_wrap=1.
- Backpressure: i_ready=0, offer 5 samples (1, 2, 3, 4, 5).
  - Required: o_ready drops after the 4th, o_count=4, the 5th is held.
  - Then i_ready=1 → o_inc = 1, 1, 1, 1, after which the 5th sample is accepted and yields 1.
- Clear marker: prev=20, push sum 4 with i_sum_clr=1 → o_inc=4, o_wrap=0 (not 240).
- Simultaneous push and pop at count=2 → count stays 2 and output order is preserved.
- Reset mid-stream:
  - With 3 entries queued, drive i_rs=0 for one cycle → o_valid=0 and o_count=0 immediately (async).
  - After release, push 7 → o_inc=7.
